camera_blob_writer: RTL and testbench
=====================================

// Module: camera_blob_writer
// PURPOSE
// - Host-side feeder for the physics Beta's shared memory. It consumes a camera luminance pixel stream and
//   thresholds each pixel to find the bright (laser/ball) blob.
// - For every frame it accumulates the pixel count, coordinate sums and bounding box.
// - At frame end it writes a 6-word record into memory_share through the host port (mwe_host/host_addr/host_din).
// - The physics Beta polls the record's sequence word and performs the centroid divide in software.
// PARAMETERS
// - THRESH     8'd200        pixel counts as "bright" when pix_data >= THRESH
// - X_W        10            x coordinate width (640 columns)
// - Y_W        9             y coordinate width (480 rows)
// - BASE_ADDR  32'h0000_0000 byte address of record word 0 in the shared region
// PORTS
// - clk         in   1   system clock
// - reset       in   1   synchronous, active-high reset
// - frame_start in   1   1-cycle pulse: first pixel of a new frame follows (or coincides)
// - line_start  in   1   1-cycle pulse: first pixel of a new line follows (or coincides)
// - pix_valid   in   1   pix_data valid this cycle
// - pix_data    in   8   luminance
// - mwe_host    out  1   write enable to memory_share host port
// - host_addr   out  32  byte address, word aligned
// - host_din    out  32  write data
// - busy        out  1   record write in progress
// - overrun     out  1   sticky: a frame end arrived while busy; cleared only by reset
// BEHAVIOUR
// - Reset values: all outputs 0; x=0, y=0; count=0; sums=0; min_x/min_y=all ones; max_x/max_y=0; seq=0; state=IDLE.
// - Coordinates:
//   - pix_valid increments x after use; line_start sets x=0 and increments y.
//   - frame_start sets x=0, y=0 (it implies line_start; never a double increment).
//   - A pixel coincident with a start pulse takes the post-update coordinate, e.g. (0,0) on frame_start.
//   - x and y saturate at all-ones; they never wrap.
// - Accumulate, for each valid pixel with pix_data >= THRESH:
//   - count+1 (20 bits)
//   - sum_x += x (32 bits)
//   - sum_y += y (32 bits)
//   - min/max update on x and y independently
// - FSM states:
//   - IDLE: waits for frame_start, then goes to ACCUM. No record is written for the partial pre-reset frame.
//   - ACCUM: on frame_start, snapshots count/sums/bbox into write registers, seq+1 (16-bit, wraps 0xFFFF->0),
//     clears accumulators, and goes to WRITE. The pixel in that same cycle is accumulated into the new frame.
//   - WRITE: drives one word per cycle for 6 cycles, then returns to ACCUM. Accumulation continues in parallel.
// - Record layout (host_addr = BASE_ADDR + 4*i, mwe_host=1):
//   - i=0 {12'b0, count}
//   - i=1 sum_x
//   - i=2 sum_y
//   - i=3 {min_y zero-extended to 16, min_x zero-extended to 16}
//   - i=4 {max_y, max_x}, each zero-extended to 16
//   - i=5 {16'b0, seq}; written last so the Beta sees a complete record when seq changes
// - Timing:
//   - Word 0 is driven the cycle after the frame_start that ends the frame; word 5 follows 5 cycles later.
//   - busy=1 on exactly those 6 cycles. mwe_host=0 outside WRITE; host_addr/host_din then hold their last value.
// - Empty frame (count=0): written as-is, i.e. bbox words 0x01FF_03FF and 0x0000_0000. Beta detects count=0.
// - frame_start while in WRITE:
//   - The current write completes unchanged and overrun is set.
//   - Accumulators still clear, but the ended frame's results are discarded and seq is not incremented.
// - Reset mid-WRITE: mwe_host=0 on the next cycle, the record is abandoned, and all state returns to reset values.
// - Count saturates at 20'hFFFFF; sums cannot overflow at 640x480.
// TESTING
// - Reset, frame_start, 3 frames of all-dark pixels (4x4 active) -> records with count=0, bbox 0x01FF_03FF/0,
//   seq=1,2 (first frame_start writes nothing).
// - Single bright pixel 255 at (5,3), THRESH=200 -> count=1, sum_x=5, sum_y=3, word3=0x0003_0005,
//   word4=0x0003_0005.
// - Bright 2x2 block at x=10..11, y=20..21 -> count=4, sum_x=42, sum_y=82, min 0x0014_000A, max 0x0015_000B;
//   addrs BASE+0..BASE+20 on 6 consecutive cycles.
// - Pixel exactly at THRESH (200) counted; pixel 199 not counted.
// - frame_start 3 cycles after the previous one -> overrun=1, only one record written, seq increments once.
// - Reset asserted at WRITE word 2 -> mwe_host=0 next cycle, seq=0, next two frame_starts write seq=1.

Source files
------------

// File: rtl/camera_blob_writer.sv
// Thresholds a luminance pixel stream, accumulates per-frame bright-blob statistics and,
// at each frame end, writes a 6-word record (count, sums, bbox, sequence) to a shared-memory host port.
module camera_blob_writer #(
  parameter logic [7:0]  THRESH    = 8'd200,
  parameter int          X_W       = 10,
  parameter int          Y_W       = 9,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_start,
  input  logic        line_start,
  input  logic        pix_valid,
  input  logic [7:0]  pix_data,
  output logic        mwe_host,
  output logic [31:0] host_addr,
  output logic [31:0] host_din,
  output logic        busy,
  output logic        overrun
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_WRITE} state_t;

  localparam logic [X_W-1:0] XMAX   = {X_W{1'b1}};
  localparam logic [Y_W-1:0] YMAX   = {Y_W{1'b1}};
  localparam logic [19:0]    CNTMAX = 20'hFFFFF;

  state_t         state_q;
  logic [X_W-1:0] x_q, x_d, cur_x, minx_q, minx_d, maxx_q, maxx_d, minx_b, maxx_b;
  logic [Y_W-1:0] y_q, y_d, cur_y, miny_q, miny_d, maxy_q, maxy_d, miny_b, maxy_b;
  logic [19:0]    cnt_q, cnt_d, cnt_b;
  logic [31:0]    sx_q, sx_d, sx_b, sy_q, sy_d, sy_b;
  logic           hit;

  logic [31:0]    wr_sx_q, wr_sy_q, wr_min_q, wr_max_q, wr_word;
  logic [15:0]    seq_q;
  logic [2:0]     widx_q;
  logic           mwe_q, busy_q, overrun_q;
  logic [31:0]    addr_q, din_q;

  // A pixel coincident with a start pulse uses the post-update coordinate.
  always_comb begin
    cur_x = (frame_start || line_start) ? '0 : x_q;
    if (frame_start)                     cur_y = '0;
    else if (line_start && y_q != YMAX)  cur_y = y_q + 1'b1;
    else                                 cur_y = y_q;
    x_d = (pix_valid && cur_x != XMAX) ? cur_x + 1'b1 : cur_x;
    y_d = cur_y;
    hit = pix_valid && (pix_data >= THRESH);

    cnt_b  = frame_start ? '0   : cnt_q;
    sx_b   = frame_start ? '0   : sx_q;
    sy_b   = frame_start ? '0   : sy_q;
    minx_b = frame_start ? XMAX : minx_q;
    miny_b = frame_start ? YMAX : miny_q;
    maxx_b = frame_start ? '0   : maxx_q;
    maxy_b = frame_start ? '0   : maxy_q;

    cnt_d  = cnt_b;
    sx_d   = sx_b;
    sy_d   = sy_b;
    minx_d = minx_b;
    miny_d = miny_b;
    maxx_d = maxx_b;
    maxy_d = maxy_b;
    if (hit) begin
      cnt_d  = (cnt_b == CNTMAX) ? cnt_b : cnt_b + 1'b1;
      sx_d   = sx_b + {{(32-X_W){1'b0}}, cur_x};
      sy_d   = sy_b + {{(32-Y_W){1'b0}}, cur_y};
      minx_d = (cur_x < minx_b) ? cur_x : minx_b;
      miny_d = (cur_y < miny_b) ? cur_y : miny_b;
      maxx_d = (cur_x > maxx_b) ? cur_x : maxx_b;
      maxy_d = (cur_y > maxy_b) ? cur_y : maxy_b;
    end
  end

  // Words 1..5 come from the snapshot; word 0 is issued directly at the snapshot edge.
  always_comb begin
    wr_word = '0;
    case (widx_q)
      3'd1:    wr_word = wr_sx_q;
      3'd2:    wr_word = wr_sy_q;
      3'd3:    wr_word = wr_min_q;
      3'd4:    wr_word = wr_max_q;
      3'd5:    wr_word = {16'b0, seq_q};
      default: wr_word = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      cnt_q     <= '0;
      sx_q      <= '0;
      sy_q      <= '0;
      minx_q    <= XMAX;
      miny_q    <= YMAX;
      maxx_q    <= '0;
      maxy_q    <= '0;
      wr_sx_q   <= '0;
      wr_sy_q   <= '0;
      wr_min_q  <= '0;
      wr_max_q  <= '0;
      seq_q     <= '0;
      widx_q    <= '0;
      mwe_q     <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      cnt_q  <= cnt_d;
      sx_q   <= sx_d;
      sy_q   <= sy_d;
      minx_q <= minx_d;
      miny_q <= miny_d;
      maxx_q <= maxx_d;
      maxy_q <= maxy_d;
      case (state_q)
        S_IDLE: begin
          if (frame_start) state_q <= S_ACCUM;
        end
        S_ACCUM: begin
          if (frame_start) begin
            wr_sx_q  <= sx_q;
            wr_sy_q  <= sy_q;
            wr_min_q <= {{(16-Y_W){1'b0}}, miny_q, {(16-X_W){1'b0}}, minx_q};
            wr_max_q <= {{(16-Y_W){1'b0}}, maxy_q, {(16-X_W){1'b0}}, maxx_q};
            seq_q    <= seq_q + 16'd1;
            widx_q   <= 3'd1;
            mwe_q    <= 1'b1;
            busy_q   <= 1'b1;
            addr_q   <= BASE_ADDR;
            din_q    <= {12'b0, cnt_q};
            state_q  <= S_WRITE;
          end
        end
        S_WRITE: begin
          // A frame end during the write loses that frame; the record in flight is untouched.
          if (frame_start) overrun_q <= 1'b1;
          if (widx_q == 3'd6) begin
            mwe_q   <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= S_ACCUM;
          end else begin
            addr_q <= BASE_ADDR + {27'b0, widx_q, 2'b00};
            din_q  <= wr_word;
            widx_q <= widx_q + 3'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mwe_host  = mwe_q;
  assign host_addr = addr_q;
  assign host_din  = din_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_camera_blob_writer.sv
// Directed bench for camera_blob_writer: a frame-level statistics model predicts each record
// word and its cycle; a negedge compare process checks the host port every cycle.
module tb_camera_blob_writer;

  logic        clk = 1'b0;
  logic        reset, frame_start, line_start, pix_valid;
  logic [7:0]  pix_data;
  logic        mwe_host, busy, overrun;
  logic [31:0] host_addr, host_din;

  always #5 clk = ~clk;

  camera_blob_writer dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .line_start(line_start),
    .pix_valid(pix_valid), .pix_data(pix_data), .mwe_host(mwe_host),
    .host_addr(host_addr), .host_din(host_din), .busy(busy), .overrun(overrun)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  int          exp_cyc_q[$];
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_q[$];

  // Frame-level model state
  bit          m_active;
  bit          m_ovr;
  int          m_last_wr;
  int          m_seq;
  int          m_cnt, m_sx, m_sy, m_minx, m_miny, m_maxx, m_maxy;
  logic [31:0] last_rec[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] pix_val(input int pat, input int x, input int y);
    case (pat)
      1:       return (x == 5 && y == 3) ? 8'd255 : 8'd30;
      2:       return (x >= 10 && x <= 11 && y >= 20 && y <= 21) ? 8'd240 : 8'd0;
      3:       return (x == 1 && y == 1) ? 8'd200 : (x == 2 && y == 1) ? 8'd199 : 8'd50;
      default: return 8'd10;
    endcase
  endfunction

  task automatic model_clear_acc();
    m_cnt = 0; m_sx = 0; m_sy = 0;
    m_minx = 1023; m_miny = 511; m_maxx = 0; m_maxy = 0;
  endtask

  // One clock: drive inputs, wait for the edge, then update the model for that edge.
  task automatic step(input bit fs, input bit ls, input bit pv, input logic [7:0] pd,
                      input int px, input int py, input bit rst);
    reset = rst; frame_start = fs; line_start = ls; pix_valid = pv; pix_data = pd;
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_active = 0; m_ovr = 0; m_seq = 0; m_last_wr = -100;
      exp_cyc_q.delete(); exp_addr_q.delete(); exp_q.delete();
      model_clear_acc();
    end else begin
      if (fs) begin
        if (!m_active) m_active = 1;
        else if (cyc <= m_last_wr + 6) m_ovr = 1;
        else begin
          m_seq = (m_seq + 1) & 32'hFFFF;
          last_rec[0] = m_cnt;
          last_rec[1] = m_sx;
          last_rec[2] = m_sy;
          last_rec[3] = (m_miny << 16) | m_minx;
          last_rec[4] = (m_maxy << 16) | m_maxx;
          last_rec[5] = m_seq;
          for (int i = 0; i < 6; i++) begin
            exp_cyc_q.push_back(cyc + i);
            exp_addr_q.push_back(32'(4 * i));
            exp_q.push_back(last_rec[i]);
          end
          m_last_wr = cyc;
        end
        model_clear_acc();
      end
      if (pv && pd >= 8'd200) begin
        m_cnt++;
        m_sx += px; m_sy += py;
        if (px < m_minx) m_minx = px;
        if (py < m_miny) m_miny = py;
        if (px > m_maxx) m_maxx = px;
        if (py > m_maxy) m_maxy = py;
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 8'd0, 0, 0, 0);
  endtask

  // Row 0 starts with frame_start, later rows with line_start; one idle cycle after each row.
  task automatic send_frame(input int pat, input int w, input int h);
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++)
        step(x == 0 && y == 0, x == 0 && y > 0, 1, pix_val(pat, x, y), x, y, 0);
      idle(1);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      if (exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc) begin
        check("mwe_write", 32'(mwe_host), 32'd1);
        check("busy_write", 32'(busy), 32'd1);
        check("host_addr", host_addr, exp_addr_q[0]);
        check("host_din", host_din, exp_q[0]);
        void'(exp_cyc_q.pop_front());
        void'(exp_addr_q.pop_front());
        void'(exp_q.pop_front());
      end else begin
        check("mwe_idle", 32'(mwe_host), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
      end
      check("overrun", 32'(overrun), 32'(m_ovr));
    end
  end

  initial begin
    step(0, 0, 0, 8'd0, 0, 0, 1);
    chk_en = 1'b1;
    step(0, 0, 0, 8'd0, 0, 0, 1);
    step(0, 0, 0, 8'd0, 0, 0, 1);
    idle(2);
    check("rst_addr", host_addr, 32'h0);
    check("rst_din", host_din, 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);

    // Three dark frames: first frame_start writes nothing, then seq 1 and 2.
    send_frame(0, 4, 4);
    send_frame(0, 4, 4);
    send_frame(0, 4, 4);
    check("dark_count", last_rec[0], 32'h0);
    check("dark_min", last_rec[3], 32'h01FF_03FF);
    check("dark_max", last_rec[4], 32'h0);
    check("dark_seq", last_rec[5], 32'd2);

    send_frame(1, 8, 5);
    send_frame(2, 12, 22);
    check("one_count", last_rec[0], 32'd1);
    check("one_sumx", last_rec[1], 32'd5);
    check("one_sumy", last_rec[2], 32'd3);
    check("one_min", last_rec[3], 32'h0003_0005);
    check("one_max", last_rec[4], 32'h0003_0005);
    check("one_seq", last_rec[5], 32'd4);

    send_frame(3, 4, 3);
    check("blk_count", last_rec[0], 32'd4);
    check("blk_sumx", last_rec[1], 32'd42);
    check("blk_sumy", last_rec[2], 32'd82);
    check("blk_min", last_rec[3], 32'h0014_000A);
    check("blk_max", last_rec[4], 32'h0015_000B);
    idle(8);
    check("hold_addr", host_addr, 32'd20);
    check("hold_din", host_din, 32'd5);

    // Threshold frame ends here; a second frame_start 3 cycles later overruns.
    step(1, 0, 0, 8'd0, 0, 0, 0);
    check("thr_count", last_rec[0], 32'd1);
    check("thr_sumx", last_rec[1], 32'd1);
    idle(2);
    step(1, 0, 0, 8'd0, 0, 0, 0);
    idle(12);
    check("ovr_sticky", 32'(overrun), 32'd1);
    step(1, 0, 0, 8'd0, 0, 0, 0);
    check("ovr_seq", last_rec[5], 32'd7);

    // Reset while word 2 is on the port.
    idle(2);
    step(0, 0, 0, 8'd0, 0, 0, 1);
    check("rst_mwe", 32'(mwe_host), 32'd0);
    idle(3);
    check("rst_ovr_clr", 32'(overrun), 32'd0);
    step(1, 0, 0, 8'd0, 0, 0, 0);
    idle(8);
    step(1, 0, 0, 8'd0, 0, 0, 0);
    idle(8);
    check("post_rst_seq", last_rec[5], 32'd1);
    check("post_rst_din", host_din, 32'd1);
    check("exp_drained", 32'(exp_q.size()), 32'd0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
